// File: rtl/divider_pkg.sv
// Shared definitions for the divider family: default operand widths, the
// IDLE/RUN/DONE state encoding, and the 32-bit-dividend range check.
package divider_pkg;

  localparam int QW = 32;
  localparam int DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // True when a reconstructed value is representable as a 32-bit dividend.
  function automatic logic fits32(input logic [QW+DW-1:0] value);
    return (value[QW+DW-1:32] == {(QW+DW-32){1'b0}});
  endfunction

endpackage

// File: rtl/dividend_reconstructor.sv
// Sequential shift-add MAC: result = quotient * divisor + remainder.
// Rebuilds a dividend from divider outputs; one operation in flight,
// fixed DW-cycle latency, back-to-back accept possible in the DONE cycle.
module dividend_reconstructor
  import divider_pkg::*;
#(
  parameter int QW = divider_pkg::QW,
  parameter int DW = divider_pkg::DW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [QW-1:0]    quotient,
  input  logic [DW-1:0]    divisor,
  input  logic [DW-1:0]    remainder,
  output logic             busy,
  output logic             valid_out,
  output logic [QW+DW-1:0] result,
  output logic             fits32
);

  localparam int RW = QW + DW;
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

  state_e          state_r;
  state_e          state_nx_s;
  logic [RW-1:0]   acc_r;
  logic [QW-1:0]   mcand_r;
  logic [DW-1:0]   mplier_r;
  logic [CW-1:0]   cnt_r;
  logic [RW-1:0]   result_r;
  logic            fits32_r;

  logic            load_s;
  logic            last_s;
  logic [RW-1:0]   addend_s;
  logic [RW-1:0]   acc_nx_s;

  // State register; reset aborts any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode: accept in IDLE or DONE, finish after DW iterations.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (valid_in) begin
          load_s     = 1'b1;
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_CNT) begin
          last_s     = 1'b1;
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE: begin
        if (valid_in) begin
          load_s     = 1'b1;
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // One shift-add iteration: add the multiplicand weighted by 2^cnt when
  // the current multiplier bit is set. The sum cannot exceed RW bits.
  always_comb begin
    addend_s = {RW{1'b0}};
    if (mplier_r[0]) begin
      addend_s = {{DW{1'b0}}, mcand_r} << cnt_r;
    end else begin
      addend_s = {RW{1'b0}};
    end
    acc_nx_s = acc_r + addend_s;
  end

  // Datapath registers: operand load, iteration update, result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r    <= {RW{1'b0}};
      mcand_r  <= {QW{1'b0}};
      mplier_r <= {DW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      result_r <= {RW{1'b0}};
      fits32_r <= 1'b1;
    end else if (load_s) begin
      acc_r    <= {{QW{1'b0}}, remainder};
      mcand_r  <= quotient;
      mplier_r <= divisor;
      cnt_r    <= {CW{1'b0}};
    end else if (state_r == RUN) begin
      acc_r    <= acc_nx_s;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + CW'(1);
      if (last_s) begin
        result_r <= acc_nx_s;
        fits32_r <= divider_pkg::fits32(acc_nx_s);
      end
    end
  end

  assign busy      = (state_r == RUN);
  assign valid_out = (state_r == DONE);
  assign result    = result_r;
  assign fits32    = fits32_r;

endmodule

// File: tb/tb_dividend_reconstructor.sv
// Directed bench for dividend_reconstructor with a cycle-level reference
// model (arithmetic product plus a latency countdown) checked every cycle.
module tb_dividend_reconstructor;

  localparam int LAT = 16;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic [31:0] quotient;
  logic [15:0] divisor;
  logic [15:0] remainder;
  logic        busy;
  logic        valid_out;
  logic [47:0] result;
  logic        fits32;

  int tests;
  int fails;

  // Reference model state
  int               m_left;
  logic             m_valid;
  longint unsigned  m_pending;
  longint unsigned  m_result;
  logic             m_fits;

  dividend_reconstructor dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .quotient  (quotient),
    .divisor   (divisor),
    .remainder (remainder),
    .busy      (busy),
    .valid_out (valid_out),
    .result    (result),
    .fits32    (fits32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: accept when not running, result appears LAT edges later.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left   = 0;
      m_valid  = 1'b0;
      m_result = 64'd0;
      m_fits   = 1'b1;
    end else begin
      m_valid = 1'b0;
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_valid  = 1'b1;
          m_result = m_pending;
          m_fits   = ((m_pending >> 32) == 64'd0);
        end
      end else if (valid_in) begin
        m_pending = 64'(quotient) * 64'(divisor) + 64'(remainder);
        m_left    = LAT;
      end
    end
  end

  // Compare process: outputs against the model on every cycle.
  always @(negedge clk) begin
    check("busy", 64'(busy), 64'(m_left > 0));
    check("valid_out", 64'(valid_out), 64'(m_valid));
    check("result", 64'(result), m_result);
    check("fits32", 64'(fits32), 64'(m_fits));
  end

  task automatic accept(input logic [31:0] q, input logic [15:0] d, input logic [15:0] r);
    quotient  = q;
    divisor   = d;
    remainder = r;
    valid_in  = 1'b1;
    @(posedge clk);
    #1;
    valid_in  = 1'b0;
    quotient  = $urandom;
    divisor   = 16'($urandom);
    remainder = 16'($urandom);
  endtask

  // Returns edges from accept until valid_out; leaves time inside DONE cycle.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (valid_out) return;
    end
    tests++;
    fails++;
    $display("FAIL wait_valid: no valid_out within 40 cycles");
    lat = -1;
  endtask

  task automatic count_valid(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (valid_out) n++;
    end
  endtask

  initial begin
    int lat;
    int n;
    tests     = 0;
    fails     = 0;
    reset     = 1'b0;
    valid_in  = 1'b0;
    quotient  = 32'd0;
    divisor   = 16'd0;
    remainder = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_valid", 64'(valid_out), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_fits32", 64'(fits32), 64'd1);
    reset = 1'b1;

    // Basic operation and latency
    accept(32'd21191, 16'd25347, 16'd4971);
    wait_valid(lat);
    check("t1_latency", 64'(lat), 64'd16);
    check("t1_result", 64'(result), 64'd537133248);
    check("t1_fits32", 64'(fits32), 64'd1);

    // Back-to-back accept in the DONE cycle
    accept(32'd27130, 16'd25443, 16'd6933);
    check("b2b_busy", 64'(busy), 64'd1);
    wait_valid(lat);
    check("b2b_latency", 64'(lat), 64'd16);
    check("b2b_result", 64'(result), 64'd690275523);
    @(posedge clk);
    #1;

    accept(32'd179044416, 16'd3, 16'd0);
    wait_valid(lat);
    check("t3_result", 64'(result), 64'd537133248);
    check("t3_fits32", 64'(fits32), 64'd1);
    @(posedge clk);
    #1;

    // Maximum operands
    accept(32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF);
    wait_valid(lat);
    check("max_result", 64'(result), 64'h0000_FFFF_0000_0000);
    check("max_fits32", 64'(fits32), 64'd0);
    @(posedge clk);
    #1;

    // Zero divisor / zero quotient
    accept(32'd12345, 16'd0, 16'd7);
    wait_valid(lat);
    check("div0_result", 64'(result), 64'd7);
    check("div0_fits32", 64'(fits32), 64'd1);
    @(posedge clk);
    #1;
    accept(32'd0, 16'd999, 16'd9);
    wait_valid(lat);
    check("q0_result", 64'(result), 64'd9);
    @(posedge clk);
    #1;

    // valid_in mid-RUN is ignored
    accept(32'd1000, 16'd3, 16'd5);
    repeat (4) @(posedge clk);
    #1;
    quotient  = 32'd7;
    divisor   = 16'd7;
    remainder = 16'd7;
    valid_in  = 1'b1;
    @(posedge clk);
    #1;
    valid_in  = 1'b0;
    count_valid(30, n);
    check("midrun_pulses", 64'(n), 64'd1);
    check("midrun_result", 64'(result), 64'd3005);

    // Asynchronous reset during iteration 8
    accept(32'd21191, 16'd25347, 16'd4971);
    repeat (8) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(valid_out), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_fits32", 64'(fits32), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    count_valid(20, n);
    check("abort_no_valid", 64'(n), 64'd0);
    accept(32'd179044416, 16'd3, 16'd0);
    wait_valid(lat);
    check("post_reset_latency", 64'(lat), 64'd16);
    check("post_reset_result", 64'(result), 64'd537133248);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
